// File: rtl/pipe_pkg.sv
// Shared encodings and constants for the pipelined CPU fetch path.
package pipe_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JR  = 2'b10,
    PCSRC_J   = 2'b11
  } pcsrc_e;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_e;

  // sll r0,r0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc_val);
    return pc_val + 32'd4;
  endfunction

endpackage

// File: rtl/pipe_if_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage and memory.
interface pipe_if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/pipe_npc_mux.sv
// Next-PC selector; the sequential leg doubles as the shared PC+4 adder.
module pipe_npc_mux
  import pipe_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  output logic [31:0] pc4,
  output logic [31:0] npc
);

  always_comb begin
    pc4 = pc_plus4(pc);
    npc = pc4;
    unique case (pcsource)
      PCSRC_SEQ: npc = pc4;
      PCSRC_BR:  npc = bpc;
      PCSRC_JR:  npc = da;
      PCSRC_J:   npc = jpc;
      default:   npc = pc4;
    endcase
  end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction fetch stage and IF/ID register with variable-latency memory handshake.
// Define IF_SQUASH_EN to drop the branch delay slot and squash the fetch on redirect.
module pipe_if_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    wpcir,
  input  logic [1:0]              pcsource,
  input  logic [31:0]             bpc,
  input  logic [31:0]             da,
  input  logic [31:0]             jpc,
  pipe_if_stage_if.master         imem,
  output logic [31:0]             pc,
  output logic [31:0]             dpc4,
  output logic [31:0]             dinst,
  output logic                    dvalid
);

`ifdef IF_SQUASH_EN
  localparam bit SquashEn = 1'b1;
`else
  localparam bit SquashEn = 1'b0;
`endif

  fetch_state_e state_q;
  logic [31:0]  pc_q, dinst_q, dpc4_q, pend_target_q, hold_inst_q, hold_pc4_q;
  logic         dvalid_q, pend_valid_q;

  logic [31:0]  pc4, npc, adv_pc;
  logic         redirect, done;

  pipe_npc_mux u_npc_mux (
    .pc       (pc_q),
    .pcsource (pcsource),
    .bpc      (bpc),
    .da       (da),
    .jpc      (jpc),
    .pc4      (pc4),
    .npc      (npc)
  );

  assign redirect = dvalid_q & wpcir & (pcsource != PCSRC_SEQ);
  assign done     = (state_q == S_FETCH) & imem.imem_ready;
  assign adv_pc   = redirect ? npc : (pend_valid_q ? pend_target_q : pc4);

  assign imem.imem_req  = resetn & (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;

  assign pc     = pc_q;
  assign dpc4   = dpc4_q;
  assign dinst  = dinst_q;
  assign dvalid = dvalid_q;

  // In squash builds pend_valid_q marks an in-flight fetch whose return must be discarded.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      dinst_q       <= NOP_INST;
      dpc4_q        <= 32'd0;
      dvalid_q      <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'd0;
      hold_inst_q   <= 32'd0;
      hold_pc4_q    <= 32'd0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (done && (wpcir || (SquashEn && pend_valid_q))) begin
            if (wpcir) begin
              if (SquashEn && (pend_valid_q || redirect)) begin
                dinst_q  <= NOP_INST;
                dvalid_q <= 1'b0;
              end else begin
                dinst_q  <= imem.imem_rdata;
                dpc4_q   <= pc4;
                dvalid_q <= 1'b1;
              end
              pc_q <= adv_pc;
            end else begin
              // squashed return under stall: IF/ID keeps the stalled instruction
              pc_q <= pend_target_q;
            end
            pend_valid_q <= 1'b0;
          end else if (done) begin
            hold_inst_q <= imem.imem_rdata;
            hold_pc4_q  <= pc4;
            state_q     <= S_HOLD;
          end else if (wpcir) begin
            dinst_q  <= NOP_INST;
            dvalid_q <= 1'b0;
            // a second redirect while one is pending is dropped
            if (redirect && !pend_valid_q) begin
              pend_valid_q  <= 1'b1;
              pend_target_q <= npc;
            end
          end
        end
        S_HOLD: begin
          if (wpcir) begin
            if (SquashEn && redirect) begin
              dinst_q  <= NOP_INST;
              dvalid_q <= 1'b0;
            end else begin
              dinst_q  <= hold_inst_q;
              dpc4_q   <= hold_pc4_q;
              dvalid_q <= 1'b1;
            end
            pc_q         <= adv_pc;
            pend_valid_q <= 1'b0;
            state_q      <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Scoreboard bench for pipe_if_stage (delay-slot build) with a variable-latency memory.
module tb_pipe_if_stage;

  localparam logic [31:0] RstPc = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        resetn, wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc, da, jpc, pc, dpc4, dinst;
  logic        dvalid;

  always #5 clock = ~clock;

  pipe_if_stage_if imem ();

  pipe_if_stage #(
    .RESET_PC (RstPc),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .wpcir    (wpcir),
    .pcsource (pcsource),
    .bpc      (bpc),
    .da       (da),
    .jpc      (jpc),
    .imem     (imem.master),
    .pc       (pc),
    .dpc4     (dpc4),
    .dinst    (dinst),
    .dvalid   (dvalid)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2001_0005;
  endfunction

  // Expected {dpc4, dinst} of every fetched word, in the order it must reach ID.
  logic [63:0] sb[$];
  logic [31:0] exp_addr, redir_tgt;
  bit          redir_out, in_hold, force_jump;
  int          wait_cnt, lat, max_lat, stall_pct, redir_pct;

  // Called just after a rising edge; drives one cycle, checks it, advances to the next edge.
  task automatic step();
    logic [31:0] tgt;
    logic [63:0] e;
    bit          redir_now, done_now, prev_wpcir, prev_valid;
    logic [31:0] prev_inst;
    tgt       = '0;
    redir_now = 1'b0;
    if (imem.imem_req) begin
      imem.imem_ready = (wait_cnt >= lat);
      imem.imem_rdata = imem.imem_ready ? mem_word(imem.imem_addr) : 32'hBAD0_0001;
    end else begin
      imem.imem_ready = 1'($urandom_range(1));
      imem.imem_rdata = 32'hBAD0_0002;
    end
    wpcir = ($urandom_range(99) >= stall_pct);
    bpc   = 32'h0000_2000 + ($urandom_range(255) << 2);
    da    = 32'h0000_4000 + ($urandom_range(255) << 2);
    jpc   = 32'h0000_8000 + ($urandom_range(255) << 2);
    if (dvalid && wpcir) begin
      if (!redir_out && (force_jump || $urandom_range(99) < redir_pct)) begin
        redir_now = 1'b1;
        if (force_jump) begin
          pcsource   = 2'b11;
          jpc        = 32'hFFFF_FFF8;
          force_jump = 1'b0;
        end else begin
          pcsource = 2'($urandom_range(3, 1));
        end
        tgt = (pcsource == 2'b01) ? bpc : (pcsource == 2'b10) ? da : jpc;
      end else begin
        pcsource = 2'b00;
      end
    end else begin
      pcsource = 2'($urandom_range(3));
    end
    #1;
    if (imem.imem_req) begin
      check("fetch_addr", imem.imem_addr, exp_addr);
      check("pc", pc, exp_addr);
    end
    if (in_hold) check("hold_req", 32'(imem.imem_req), 32'd0);
    if (!dvalid) check("bubble_inst", dinst, 32'h0);
    if (dvalid && wpcir) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty: got valid %08h expected none queued", dinst);
      end else begin
        e = sb.pop_front();
        check("dinst", dinst, e[31:0]);
        check("dpc4", dpc4, e[63:32]);
      end
    end
    done_now = imem.imem_req && imem.imem_ready;
    if (done_now) begin
      sb.push_back({imem.imem_addr + 32'd4, mem_word(imem.imem_addr)});
      if (redir_now) begin
        exp_addr = tgt;
      end else if (redir_out) begin
        exp_addr  = redir_tgt;
        redir_out = 1'b0;
      end else begin
        exp_addr = imem.imem_addr + 32'd4;
      end
      in_hold  = !wpcir;
      wait_cnt = 0;
      lat      = $urandom_range(max_lat);
    end else begin
      if (imem.imem_req) wait_cnt++;
      if (in_hold && wpcir) begin
        in_hold = 1'b0;
        if (redir_now) exp_addr = tgt;
      end else if (redir_now) begin
        redir_out = 1'b1;
        redir_tgt = tgt;
      end
    end
    prev_wpcir = wpcir;
    prev_inst  = dinst;
    prev_valid = dvalid;
    @(posedge clock);
    #1;
    if (!prev_wpcir) begin
      check("stall_inst", dinst, prev_inst);
      check("stall_valid", 32'(dvalid), 32'(prev_valid));
    end
  endtask

  task automatic clear_model();
    sb.delete();
    exp_addr  = RstPc;
    redir_out = 1'b0;
    in_hold   = 1'b0;
    wait_cnt  = 0;
    lat       = 0;
  endtask

  initial begin
    resetn          = 1'b0;
    wpcir           = 1'b1;
    pcsource        = 2'b00;
    bpc             = '0;
    da              = '0;
    jpc             = '0;
    imem.imem_ready = 1'b0;
    imem.imem_rdata = '0;
    force_jump      = 1'b0;
    max_lat = 0; stall_pct = 0; redir_pct = 0;
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    check("rst_pc", pc, RstPc);
    check("rst_dinst", dinst, 32'h0);
    check("rst_dpc4", dpc4, 32'h0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_req", 32'(imem.imem_req), 32'd0);
    resetn = 1'b1;

    // zero-wait streaming, then random latency, stalls and redirects
    repeat (12) step();
    max_lat = 3; stall_pct = 25; redir_pct = 20;
    repeat (300) step();

    // jump near the top of the address space to exercise PC wrap
    redir_pct  = 0;
    force_jump = 1'b1;
    for (int i = 0; i < 60 && force_jump; i++) step();
    if (force_jump) begin
      checks++;
      failures++;
      $display("FAIL wrap_jump: got not taken expected taken");
      force_jump = 1'b0;
    end
    repeat (25) step();

    // reset while a fetch is outstanding, with a stale ready during reset
    for (int i = 0; i < 20 && !imem.imem_req; i++) step();
    lat = 100;
    repeat (2) step();
    resetn          = 1'b0;
    wpcir           = 1'b1;
    pcsource        = 2'b00;
    imem.imem_ready = 1'b1;
    imem.imem_rdata = 32'h5757_5757;
    #1;
    check("midrst_req", 32'(imem.imem_req), 32'd0);
    @(posedge clock);
    #1;
    check("midrst_pc", pc, RstPc);
    check("midrst_dvalid", 32'(dvalid), 32'd0);
    check("midrst_dinst", dinst, 32'h0);
    resetn = 1'b1;
    clear_model();
    max_lat = 3; stall_pct = 25; redir_pct = 20;
    repeat (150) step();

    // drain with a zero-wait memory; only the word now in ID may remain queued
    max_lat = 0; stall_pct = 0; redir_pct = 0;
    repeat (12) step();
    check("sb_residue", 32'(sb.size()), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_if_stage.md
Name: pipe_if_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the five-stage pipelined CPU. It sits directly upstream of the decode-stage control unit.
- Owns the PC and selects the next PC from the decode-stage `pcsource` select.
- Fetches from a variable-latency instruction memory through a req/ready handshake.
- Presents `dinst`/`dpc4` to decode. Honours the `wpcir` stall and inserts NOP bubbles when fetch is late.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0000, bubble instruction driven into ID (sll r0,r0,0).

Ports:
clock  input  1  system clock, all state on rising edge
resetn  input  1  synchronous active-low reset
wpcir  input  1  1 = PC and IF/ID may advance; 0 = load/use stall
pcsource  input  2  next-PC select from decode: 00 pc+4, 01 bpc, 10 da, 11 jpc
bpc  input  32  branch target
da  input  32  jr target (register value)
jpc  input  32  jump target
imem_req  output  1  fetch request
imem_addr  output  32  fetch address (= pc)
imem_rdata  input  32  fetched word, valid when imem_ready
imem_ready  input  1  fetch completes this cycle
pc  output  32  current fetch PC
dpc4  output  32  IF/ID: PC+4 of instruction in ID
dinst  output  32  IF/ID: instruction in ID
dvalid  output  1  IF/ID: 1 = real instruction, 0 = bubble

Behaviour:
- Reset (resetn=0 at edge): pc=RESET_PC, dinst=NOP_INST, dpc4=0, dvalid=0, state=S_FETCH, pend_valid=0, hold buffer cleared. imem_req is forced low while resetn=0.
- redirect = dvalid & wpcir & (pcsource!=00). It means the ID instruction is consumed this cycle and transfers control. target = mux(pcsource: 01 bpc, 10 da, 11 jpc).
- `pcsource` is ignored when dvalid=0.
- Handshake: imem_req=1 only in S_FETCH. imem_addr=pc, held stable until imem_ready. imem_ready while imem_req=0 is ignored.
- done = S_FETCH & imem_ready.
- S_FETCH, done & wpcir:
  - dinst<=imem_rdata, dpc4<=pc+4, dvalid<=1.
  - pc<= target if redirect; else pend_target if pend_valid; else pc+4.
  - Clear pend_valid. Stay in S_FETCH.
- S_FETCH, done & ~wpcir: buffer imem_rdata and pc+4, IF/ID unchanged, pc unchanged, go to S_HOLD.
- S_FETCH, ~done & wpcir:
  - IF/ID <= bubble (NOP_INST, dvalid=0), since the ID instruction has been consumed.
  - If redirect: pend_valid<=1, pend_target<=target.
  - pc unchanged.
- S_FETCH, ~done & ~wpcir: all registers hold.
- S_HOLD: imem_req=0. When wpcir=1:
  - IF/ID <= buffer, dvalid<=1.
  - pc<= target if redirect; else pend_target if pend_valid; else pc+4.
  - Clear pend_valid, go to S_FETCH.
- S_HOLD with wpcir=0: hold.
- Branch delay slot: the word fetched after a control transfer executes. The PC update is deferred to the end of that fetch.
- A control transfer in a delay slot is unsupported. An existing pending target is kept and the second redirect is dropped.
- All PC arithmetic is 32-bit modulo 2^32. pc+4 wraps from 32'hFFFF_FFFC to 0.
- Reset mid-fetch: the outstanding request is abandoned. A late imem_ready is ignored only while imem_req=0; the memory must drop the request on reset.

Optional Feature:
IF_SQUASH_EN: when defined, there is no delay slot.
- On redirect, the word being fetched or held is discarded: a same-cycle done loads a bubble; S_HOLD drops its buffer.
- An in-flight fetch sets squash=1 and its return loads a bubble. pc<=target in all cases.
- Undefined: delay-slot behaviour as above.

Decomposition:
- Package pipe_pkg holds:
  - PCSRC_SEQ/BR/JR/J encodings;
  - the fetch state enum (S_FETCH, S_HOLD);
  - the NOP_INST constant.
- One sub-module, pipe_npc_mux: a combinational 4:1 next-PC selector shared with the PC adder.

Test Plan:
1. Zero-wait memory (imem_ready=1 always), RESET_PC=0, words 0x20010005, ... -> imem_addr 0,4,8. dinst tracks one cycle behind, dpc4=4,8,12, dvalid=1.
2. wpcir=0 for 2 cycles with the fetch at pc=8 done -> state S_HOLD, imem_req=0, dinst stable. On release, dinst=word@8 and pc=0xC.
3. Memory latency 3 cycles, wpcir=1 -> two bubbles (dinst=0, dvalid=0) between instructions. pc advances only on imem_ready.
4. beq in ID with pcsource=01, bpc=0x40, fetch of pc=0x14 pending 2 cycles -> pend_valid set. Word@0x14 enters ID (delay slot), then pc=0x40.
5. jr with pcsource=10, da=0x100 in the same cycle as done -> pc=0x100 next cycle. With IF_SQUASH_EN, the next dinst is a bubble.
6. resetn=0 asserted mid-wait -> next cycle pc=RESET_PC, dvalid=0, state S_FETCH. A stale imem_ready during reset is not captured.
